// File: rtl/cr_isf_dbg_step_ctl.sv
// ISF ingress debug trigger / single-step flow controller on the AXI4-S beat path.
// Optional stall watchdog enabled by defining CR_ISF_DBG_STALL_WDOG_EN.
module cr_isf_dbg_step_ctl #(
    parameter int DATA_W  = 64,
    parameter int USER_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_tvalid,
    output logic                in_tready,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic [DATA_W/8-1:0] in_tstrb,
    input  logic [USER_W-1:0]   in_tuser,
    input  logic                in_tlast,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic [DATA_W-1:0]   out_tdata,
    output logic [DATA_W/8-1:0] out_tstrb,
    output logic [USER_W-1:0]   out_tuser,
    output logic                out_tlast,
    input  logic                dbg_en,
    input  logic                arm,
    input  logic                step_req,
    input  logic                resume,
    input  logic [DATA_W-1:0]   trig_mask,
    input  logic [DATA_W-1:0]   trig_match,
    input  logic [STALL_W-1:0]  stall_limit,
    output logic [DATA_W-1:0]   trig_cap,
    output logic [DATA_W-1:0]   ss_cap,
    output logic [USER_W+1:0]   ss_cap_sb,
    output logic                halted,
    output logic [7:0]          trig_cnt,
    output logic                stall_int
);

    typedef enum logic [1:0] {
        ST_PASS,
        ST_ARMED,
        ST_HALT,
        ST_STEP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_sop;
    logic [DATA_W-1:0]   r_trig_cap;
    logic [DATA_W-1:0]   r_ss_cap;
    logic [USER_W+1:0]   r_ss_cap_sb;
    logic [7:0]          r_trig_cnt;
    logic                w_halted;
    logic                w_hit;
    logic                w_gate;
    logic                w_acc;
    logic                w_trig;
    logic                w_wdog_exp;

    assign w_halted = (r_state == ST_HALT) || (r_state == ST_STEP);

    // Only the first beat of a TLV can trigger; the hit beat is held back.
    assign w_hit = (r_state == ST_ARMED) && in_tvalid && r_sop &&
                   (((in_tdata ^ trig_match) & trig_mask) == '0);

    assign w_gate = (r_state == ST_PASS) ||
                    ((r_state == ST_ARMED) && !w_hit) ||
                    (r_state == ST_STEP);

    assign out_tvalid = in_tvalid & w_gate;
    assign in_tready  = out_tready & w_gate;
    assign out_tdata  = in_tdata;
    assign out_tstrb  = in_tstrb;
    assign out_tuser  = in_tuser;
    assign out_tlast  = in_tlast;

    assign w_acc  = in_tvalid & in_tready;
    assign w_trig = w_hit & dbg_en;

`ifdef CR_ISF_DBG_STALL_WDOG_EN
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_stall_int;

    assign w_wdog_exp = dbg_en && w_halted && (stall_limit != '0) &&
                        (r_stall_cnt == (stall_limit - STALL_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_stall_int <= 1'b0;
        end else begin
            r_stall_int <= w_wdog_exp;
            if (w_trig)
                r_stall_cnt <= '0;
            else if (w_halted && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign stall_int = r_stall_int;
`else
    logic w_unused_limit;

    assign w_unused_limit = ^stall_limit;
    assign w_wdog_exp     = 1'b0;
    assign stall_int      = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (!dbg_en)
            w_next = ST_PASS;
        else if (w_wdog_exp)
            w_next = ST_PASS;
        else if (resume && w_halted)
            w_next = ST_PASS;
        else begin
            unique case (r_state)
                ST_PASS:  if (arm)      w_next = ST_ARMED;
                ST_ARMED: if (w_hit)    w_next = ST_HALT;
                ST_HALT:  if (step_req) w_next = ST_STEP;
                ST_STEP:  if (w_acc)    w_next = ST_HALT;
                default:                w_next = ST_PASS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_PASS;
            r_sop       <= 1'b1;
            r_trig_cap  <= '0;
            r_trig_cnt  <= '0;
            r_ss_cap    <= '0;
            r_ss_cap_sb <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc)
                r_sop <= in_tlast;
            if (w_trig) begin
                r_trig_cap <= in_tdata;
                if (r_trig_cnt != 8'hFF)
                    r_trig_cnt <= r_trig_cnt + 8'd1;
            end
            // A stepped beat is captured even if resume lands in the same cycle.
            if ((r_state == ST_STEP) && w_acc) begin
                r_ss_cap    <= in_tdata;
                r_ss_cap_sb <= {in_tuser, in_tlast, r_sop};
            end
        end
    end

    assign halted    = w_halted;
    assign trig_cap  = r_trig_cap;
    assign trig_cnt  = r_trig_cnt;
    assign ss_cap    = r_ss_cap;
    assign ss_cap_sb = r_ss_cap_sb;

endmodule

// File: tb/tb_cr_isf_dbg_step_ctl.sv
// Directed bench for cr_isf_dbg_step_ctl: pass-through, trigger, stepping,
// watchdog (CR_ISF_DBG_STALL_WDOG_EN) and control priority.
module tb_cr_isf_dbg_step_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_tvalid;
    logic        in_tready;
    logic [63:0] in_tdata;
    logic [7:0]  in_tstrb;
    logic [7:0]  in_tuser;
    logic        in_tlast;
    logic        out_tvalid;
    logic        out_tready;
    logic [63:0] out_tdata;
    logic [7:0]  out_tstrb;
    logic [7:0]  out_tuser;
    logic        out_tlast;
    logic        dbg_en;
    logic        arm;
    logic        step_req;
    logic        resume;
    logic [63:0] trig_mask;
    logic [63:0] trig_match;
    logic [15:0] stall_limit;
    logic [63:0] trig_cap;
    logic [63:0] ss_cap;
    logic [9:0]  ss_cap_sb;
    logic        halted;
    logic [7:0]  trig_cnt;
    logic        stall_int;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    beat_t       src_q[$];
    logic [63:0] out_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    cr_isf_dbg_step_ctl #(.DATA_W(64), .USER_W(8), .STALL_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tstrb(in_tstrb), .in_tuser(in_tuser), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tstrb(out_tstrb), .out_tuser(out_tuser), .out_tlast(out_tlast),
        .dbg_en(dbg_en), .arm(arm), .step_req(step_req), .resume(resume),
        .trig_mask(trig_mask), .trig_match(trig_match), .stall_limit(stall_limit),
        .trig_cap(trig_cap), .ss_cap(ss_cap), .ss_cap_sb(ss_cap_sb),
        .halted(halted), .trig_cnt(trig_cnt), .stall_int(stall_int)
    );

    function automatic beat_t mk(input logic [63:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.u = d[7:0] ^ 8'hA0;
        b.l = l;
        return b;
    endfunction

    // Upstream source (holds each beat until accepted) and egress monitor.
    initial begin
        logic hs;
        in_tvalid = 1'b0;
        in_tdata  = '0;
        in_tstrb  = '0;
        in_tuser  = '0;
        in_tlast  = 1'b0;
        forever begin
            @(negedge clk);
            hs = in_tvalid && in_tready;
            if (out_tvalid && out_tready)
                out_q.push_back(out_tdata);
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0)
                void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                in_tvalid = 1'b1;
                in_tdata  = src_q[0].d;
                in_tuser  = src_q[0].u;
                in_tlast  = src_q[0].l;
                in_tstrb  = src_q[0].d[15:8];
            end else begin
                in_tvalid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        @(posedge clk); #1; arm = 1'b1;
        @(posedge clk); #1; arm = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1; step_req = 1'b1;
        @(posedge clk); #1; step_req = 1'b0;
    endtask

    task automatic pulse_resume();
        @(posedge clk); #1; resume = 1'b1;
        @(posedge clk); #1; resume = 1'b0;
    endtask

    task automatic wait_halted(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (src_q.size() == 0 && in_tvalid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_tready = 1'b1;
        tick(3);
        @(negedge clk);
        n_vec++;
        if (halted !== 1'b0 || stall_int !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got halted=%b stall_int=%b exp 0/0", halted, stall_int);
        end
        n_vec++;
        if (trig_cnt !== 8'd0 || trig_cap !== 64'd0) begin
            n_err++;
            $display("FAIL reset_trig got cnt=%0d cap=%h exp 0/0", trig_cnt, trig_cap);
        end
        n_vec++;
        if (ss_cap !== 64'd0 || ss_cap_sb !== 10'd0) begin
            n_err++;
            $display("FAIL reset_ss got cap=%h sb=%h exp 0/0", ss_cap, ss_cap_sb);
        end
        n_vec++;
        if (in_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready got=%b exp=1", in_tready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [63:0] exp_q[$];
        logic [63:0] d;
        bit          done;
        dbg_en = 1'b0;
        trig_mask = '0;
        trig_match = '0;
        out_q.delete();
        pulse_arm();
        for (int i = 0; i < 100; i++) begin
            d = {$urandom, $urandom};
            src_q.push_back(mk(d, ($urandom_range(0, 3) == 0)));
            exp_q.push_back(d);
        end
        done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            out_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_vec++;
            if (out_tvalid !== in_tvalid || in_tready !== out_tready ||
                out_tdata !== in_tdata || out_tstrb !== in_tstrb ||
                out_tuser !== in_tuser || out_tlast !== in_tlast || halted !== 1'b0) begin
                n_err++;
                $display("FAIL pass_cycle got v=%b r=%b d=%h h=%b exp v=%b r=%b d=%h h=0",
                         out_tvalid, in_tready, out_tdata, halted,
                         in_tvalid, out_tready, in_tdata);
            end
            if (src_q.size() == 0 && in_tvalid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL pass_drain got=timeout exp=drained");
        end
        n_vec++;
        if (out_q.size() != 100) begin
            n_err++;
            $display("FAIL pass_count got=%0d exp=100", out_q.size());
        end
        for (int i = 0; i < 100; i++) begin
            n_vec++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL pass_data[%0d] got=%h exp=%h", i, out_q[i], exp_q[i]);
            end
        end
        out_tready = 1'b1;
    endtask

    task automatic test_trigger();
        logic [63:0] e[5];
        bit          ok;
        e = '{64'h1111_0000_0000_0001, 64'h1111_0000_0000_0002,
              64'h2222_0000_0000_0001, 64'h2222_0000_0000_0002,
              64'h2222_0000_0000_0003};
        dbg_en = 1'b1;
        out_tready = 1'b1;
        trig_mask  = 64'hFFFF_0000_0000_0000;
        trig_match = 64'h00AB_0000_0000_0000;
        out_q.delete();
        pulse_arm();
        src_q.push_back(mk(64'h1111_0000_0000_0001, 1'b0));
        src_q.push_back(mk(64'h1111_0000_0000_0002, 1'b1));
        src_q.push_back(mk(64'h2222_0000_0000_0001, 1'b0));
        src_q.push_back(mk(64'h2222_0000_0000_0002, 1'b0));
        src_q.push_back(mk(64'h2222_0000_0000_0003, 1'b1));
        src_q.push_back(mk(64'h00AB_1234_5678_9ABC, 1'b0));
        src_q.push_back(mk(64'h3000_0000_0000_0001, 1'b0));
        src_q.push_back(mk(64'h3000_0000_0000_0002, 1'b0));
        src_q.push_back(mk(64'h3000_0000_0000_0003, 1'b1));
        src_q.push_back(mk(64'h4444_0000_0000_0001, 1'b1));
        wait_halted(50, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL trig_halt got=timeout exp=halted");
        end
        tick(3);
        @(negedge clk);
        n_vec++;
        if (halted !== 1'b1 || out_tvalid !== 1'b0 || in_tready !== 1'b0) begin
            n_err++;
            $display("FAIL trig_hold got h=%b v=%b r=%b exp 1/0/0", halted, out_tvalid, in_tready);
        end
        n_vec++;
        if (trig_cap !== 64'h00AB_1234_5678_9ABC) begin
            n_err++;
            $display("FAIL trig_cap got=%h exp=00ab123456789abc", trig_cap);
        end
        n_vec++;
        if (trig_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL trig_cnt got=%0d exp=1", trig_cnt);
        end
        n_vec++;
        if (out_q.size() != 5) begin
            n_err++;
            $display("FAIL trig_fwd_count got=%0d exp=5", out_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (i >= out_q.size() || out_q[i] !== e[i]) begin
                n_err++;
                $display("FAIL trig_fwd[%0d] got=%h exp=%h", i, out_q[i], e[i]);
            end
        end
    endtask

    task automatic test_single_step();
        bit ok;
        out_q.delete();
        pulse_step();
        tick(3);
        @(negedge clk);
        n_vec++;
        if (ss_cap !== 64'h00AB_1234_5678_9ABC || ss_cap_sb !== 10'h071) begin
            n_err++;
            $display("FAIL step1_cap got=%h/%h exp=00ab123456789abc/071", ss_cap, ss_cap_sb);
        end
        n_vec++;
        if (out_q.size() != 1 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL step1_count got=%0d h=%b exp=1 h=1", out_q.size(), halted);
        end
        @(posedge clk); #1;
        out_tready = 1'b0;
        pulse_step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_tvalid !== 1'b1 || in_tready !== 1'b0 || halted !== 1'b1) begin
                n_err++;
                $display("FAIL step2_stall got v=%b r=%b h=%b exp 1/0/1", out_tvalid, in_tready, halted);
            end
            @(posedge clk); #1;
        end
        out_tready = 1'b1;
        tick(3);
        pulse_step();
        tick(3);
        @(negedge clk);
        n_vec++;
        if (out_q.size() != 3) begin
            n_err++;
            $display("FAIL step3_count got=%0d exp=3", out_q.size());
        end
        n_vec++;
        if (out_q.size() < 3 || out_q[1] !== 64'h3000_0000_0000_0001 ||
            out_q[2] !== 64'h3000_0000_0000_0002) begin
            n_err++;
            $display("FAIL step_order got=%h,%h exp=3000000000000001,3000000000000002",
                     out_q[1], out_q[2]);
        end
        n_vec++;
        if (ss_cap !== 64'h3000_0000_0000_0002 || ss_cap_sb !== 10'h288) begin
            n_err++;
            $display("FAIL step3_cap got=%h/%h exp=3000000000000002/288", ss_cap, ss_cap_sb);
        end
        pulse_resume();
        wait_drain(100, ok);
        n_vec++;
        if (!ok || halted !== 1'b0) begin
            n_err++;
            $display("FAIL resume_drain got ok=%b h=%b exp 1/0", ok, halted);
        end
        n_vec++;
        if (out_q.size() != 5 || out_q[3] !== 64'h3000_0000_0000_0003 ||
            out_q[4] !== 64'h4444_0000_0000_0001) begin
            n_err++;
            $display("FAIL resume_tail got n=%0d %h,%h exp 5 3000000000000003,4444000000000001",
                     out_q.size(), out_q[3], out_q[4]);
        end
    endtask

    task automatic test_midtlv_nomatch();
        bit ok;
        out_q.delete();
        pulse_arm();
        src_q.push_back(mk(64'h5555_0000_0000_0001, 1'b0));
        src_q.push_back(mk(64'h00AB_FFFF_0000_0000, 1'b0));
        src_q.push_back(mk(64'h5555_0000_0000_0003, 1'b1));
        src_q.push_back(mk(64'h00AB_0000_0000_0042, 1'b1));
        src_q.push_back(mk(64'h6666_0000_0000_0001, 1'b1));
        wait_halted(50, ok);
        n_vec++;
        if (!ok || out_q.size() != 3) begin
            n_err++;
            $display("FAIL mid_nohit got ok=%b fwd=%0d exp 1/3", ok, out_q.size());
        end
        n_vec++;
        if (trig_cap !== 64'h00AB_0000_0000_0042 || trig_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL mid_trig got cap=%h cnt=%0d exp 00ab000000000042/2", trig_cap, trig_cnt);
        end
        pulse_resume();
        wait_drain(100, ok);
        n_vec++;
        if (!ok || out_q.size() != 5 || out_q[3] !== 64'h00AB_0000_0000_0042) begin
            n_err++;
            $display("FAIL mid_drain got ok=%b n=%0d d3=%h exp 1/5/00ab000000000042",
                     ok, out_q.size(), out_q[3]);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        bit bad;
        stall_limit = 16'd10;
        out_q.delete();
        pulse_arm();
        src_q.push_back(mk(64'h00AB_5555_0000_0001, 1'b1));
        wait_halted(50, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL wd_halt got=timeout exp=halted");
        end
`ifdef CR_ISF_DBG_STALL_WDOG_EN
        begin
            int cyc;
            cyc = -1;
            for (int i = 0; i <= 20; i++) begin
                if (i > 0)
                    @(negedge clk);
                if (stall_int === 1'b1) begin
                    cyc = i;
                    break;
                end
            end
            n_vec++;
            if (cyc != 10) begin
                n_err++;
                $display("FAIL wd_latency got=%0d exp=10", cyc);
            end
            n_vec++;
            if (halted !== 1'b0) begin
                n_err++;
                $display("FAIL wd_release got h=%b exp=0", halted);
            end
            @(negedge clk);
            n_vec++;
            if (stall_int !== 1'b0) begin
                n_err++;
                $display("FAIL wd_pulse_width got=%b exp=0", stall_int);
            end
        end
        wait_drain(100, ok);
        n_vec++;
        if (!ok || out_q.size() != 1) begin
            n_err++;
            $display("FAIL wd_drain got ok=%b n=%0d exp 1/1", ok, out_q.size());
        end
        stall_limit = 16'd0;
        out_q.delete();
        pulse_arm();
        src_q.push_back(mk(64'h00AB_5555_0000_0002, 1'b1));
        wait_halted(50, ok);
        bad = !ok;
        repeat (1000) begin
            @(negedge clk);
            if (halted !== 1'b1 || stall_int !== 1'b0)
                bad = 1'b1;
        end
`else
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (halted !== 1'b1 || stall_int !== 1'b0)
                bad = 1'b1;
        end
`endif
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL wd_persist got=released exp=halted");
        end
        pulse_resume();
        wait_drain(100, ok);
        n_vec++;
        if (!ok || out_q.size() != 1) begin
            n_err++;
            $display("FAIL wd_resume got ok=%b n=%0d exp 1/1", ok, out_q.size());
        end
        stall_limit = 16'd0;
    endtask

    task automatic test_priority();
        bit ok;
        out_tready = 1'b1;
        out_q.delete();
        pulse_arm();
        src_q.push_back(mk(64'h00AB_0000_0000_00A1, 1'b0));
        src_q.push_back(mk(64'h7000_0000_0000_0002, 1'b1));
        wait_halted(50, ok);
        @(posedge clk); #1;
        resume = 1'b1;
        step_req = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        step_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (!ok || halted !== 1'b0 || out_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL prio_resume got ok=%b h=%b v=%b exp 1/0/1", ok, halted, out_tvalid);
        end
        wait_drain(100, ok);
        n_vec++;
        if (!ok || out_q.size() != 2 || ss_cap !== 64'h3000_0000_0000_0002) begin
            n_err++;
            $display("FAIL prio_nostep got n=%0d ss=%h exp 2/3000000000000002", out_q.size(), ss_cap);
        end
        out_q.delete();
        pulse_arm();
        src_q.push_back(mk(64'h00AB_0000_0000_00B1, 1'b0));
        src_q.push_back(mk(64'h7000_0000_0000_0004, 1'b1));
        wait_halted(50, ok);
        @(posedge clk); #1;
        out_tready = 1'b0;
        pulse_step();
        @(posedge clk); #1;
        dbg_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (!ok || halted !== 1'b1) begin
            n_err++;
            $display("FAIL dben_step got ok=%b h=%b exp 1/1", ok, halted);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (halted !== 1'b0 || ss_cap !== 64'h3000_0000_0000_0002) begin
            n_err++;
            $display("FAIL dben_release got h=%b ss=%h exp 0/3000000000000002", halted, ss_cap);
        end
        out_tready = 1'b1;
        wait_drain(100, ok);
        n_vec++;
        if (!ok || out_q.size() != 2) begin
            n_err++;
            $display("FAIL dben_drain got ok=%b n=%0d exp 1/2", ok, out_q.size());
        end
        dbg_en = 1'b1;
        out_q.delete();
        pulse_arm();
        src_q.push_back(mk(64'h00AB_0000_0000_00C1, 1'b1));
        wait_halted(50, ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (!ok || halted !== 1'b0 || stall_int !== 1'b0 || in_tready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_halt got ok=%b h=%b si=%b r=%b exp 1/0/0/1",
                     ok, halted, stall_int, in_tready);
        end
        n_vec++;
        if (trig_cnt !== 8'd0 || trig_cap !== 64'd0 || ss_cap !== 64'd0 || ss_cap_sb !== 10'd0) begin
            n_err++;
            $display("FAIL rst_caps got cnt=%0d tc=%h ss=%h sb=%h exp 0/0/0/0",
                     trig_cnt, trig_cap, ss_cap, ss_cap_sb);
        end
        wait_drain(100, ok);
        n_vec++;
        if (!ok || out_q.size() != 1) begin
            n_err++;
            $display("FAIL rst_drain got ok=%b n=%0d exp 1/1", ok, out_q.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        out_tready  = 1'b0;
        dbg_en      = 1'b0;
        arm         = 1'b0;
        step_req    = 1'b0;
        resume      = 1'b0;
        trig_mask   = '0;
        trig_match  = '0;
        stall_limit = '0;
        test_reset();
        test_pass_through();
        test_trigger();
        test_single_step();
        test_midtlv_nomatch();
        test_watchdog();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
